// File: rtl/lfsr_pkg.sv
// Shared definitions for the 49-bit XNOR-form LFSR generator/checker pair.
// Holds the default geometry, the checker state encoding and the next-state function.
package lfsr_pkg;

    localparam int LFSR_NUM_BITS = 49;
    localparam int LFSR_TAP_A    = 49;
    localparam int LFSR_TAP_B    = 40;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } lfsr_state_e;

    // Shift left by one and insert the XNOR of the two taps (taps are 1-based).
    function automatic logic [LFSR_NUM_BITS-1:0] lfsr_next(input logic [LFSR_NUM_BITS-1:0] x);
        return {x[LFSR_NUM_BITS-2:0], ~(x[LFSR_TAP_A-1] ^ x[LFSR_TAP_B-1])};
    endfunction

endpackage

// File: rtl/lfsr_checker.sv
// Receive-side LFSR stream checker: self-synchronises to a word-parallel XNOR LFSR,
// then flywheels its prediction and counts mismatches, words and the stop code.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int NUM_BITS = LFSR_NUM_BITS,
    parameter int TAP_A    = LFSR_TAP_A,
    parameter int TAP_B    = LFSR_TAP_B,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 4,
    parameter int CNT_W    = 32
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_clear,
    input  logic                i_vld,
    input  logic [NUM_BITS-1:0] i_data,
    input  logic [NUM_BITS-1:0] i_stop_code,
    output logic                o_locked,
    output logic                o_err,
    output logic [CNT_W-1:0]    o_err_cnt,
    output logic [CNT_W-1:0]    o_word_cnt,
    output logic                o_done,
    output logic [NUM_BITS-1:0] o_exp_data
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_CNT + 1);
    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
    localparam logic [LW-1:0] MISS_LAST  = LW'(LOSS_CNT - 1);

    lfsr_state_e         state_q;
    logic [NUM_BITS-1:0] prev_q;
    logic [MW-1:0]       match_q;
    logic [LW-1:0]       miss_q;
    logic                err_q;
    logic                done_q;
    logic [CNT_W-1:0]    err_cnt_q;
    logic [CNT_W-1:0]    word_cnt_q;

    logic [NUM_BITS-1:0] predict_d;
    logic                word_ok;
    logic                all_ones;

    function automatic logic [NUM_BITS-1:0] next_word(input logic [NUM_BITS-1:0] x);
        return {x[NUM_BITS-2:0], ~(x[TAP_A-1] ^ x[TAP_B-1])};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    assign predict_d = next_word(prev_q);
    assign word_ok   = (i_data == predict_d);
    // All-ones is the XNOR lockup state: it predicts itself, so it must never seed.
    assign all_ones  = &i_data;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            prev_q     <= '0;
            match_q    <= '0;
            miss_q     <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            err_cnt_q  <= '0;
            word_cnt_q <= '0;
        end else begin
            err_q <= 1'b0;
            if (i_clear) begin
                state_q    <= IDLE;
                prev_q     <= '0;
                match_q    <= '0;
                miss_q     <= '0;
                done_q     <= 1'b0;
                err_cnt_q  <= '0;
                word_cnt_q <= '0;
            end else if (i_vld) begin
                case (state_q)
                    IDLE: begin
                        match_q <= '0;
                        if (!all_ones) begin
                            prev_q  <= i_data;
                            state_q <= ACQUIRE;
                        end
                    end
                    ACQUIRE: begin
                        if (all_ones) begin
                            match_q <= '0;
                            state_q <= IDLE;
                        end else if (word_ok) begin
                            prev_q <= i_data;
                            if (match_q == MATCH_LAST) begin
                                match_q <= '0;
                                miss_q  <= '0;
                                state_q <= LOCKED;
                            end else begin
                                match_q <= match_q + MW'(1);
                            end
                        end else begin
                            prev_q  <= i_data;
                            match_q <= '0;
                        end
                    end
                    LOCKED: begin
                        word_cnt_q <= sat_inc(word_cnt_q);
                        // Flywheel: the prediction advances regardless of what arrived.
                        prev_q     <= predict_d;
                        if (word_ok) begin
                            miss_q <= '0;
                            if (i_data == i_stop_code) begin
                                done_q <= 1'b1;
                            end
                        end else begin
                            err_q     <= 1'b1;
                            err_cnt_q <= sat_inc(err_cnt_q);
                            if (miss_q == MISS_LAST) begin
                                miss_q  <= '0;
                                match_q <= '0;
                                if (all_ones) begin
                                    state_q <= IDLE;
                                end else begin
                                    prev_q  <= i_data;
                                    state_q <= ACQUIRE;
                                end
                            end else begin
                                miss_q <= miss_q + LW'(1);
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        match_q <= '0;
                        miss_q  <= '0;
                    end
                endcase
            end
        end
    end

    assign o_locked   = (state_q == LOCKED);
    assign o_err      = err_q;
    assign o_err_cnt  = err_cnt_q;
    assign o_word_cnt = word_cnt_q;
    assign o_done     = done_q;
    assign o_exp_data = prev_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: a driver pushes hand-derived expectations per beat,
// a monitor pops and compares them one edge later.
module tb_lfsr_checker;

    localparam int NB = 49;

    logic          clk;
    logic          rst;
    logic          i_clear;
    logic          i_vld;
    logic [NB-1:0] i_data;
    logic [NB-1:0] i_stop_code;
    logic          o_locked;
    logic          o_err;
    logic [31:0]   o_err_cnt;
    logic [31:0]   o_word_cnt;
    logic          o_done;
    logic [NB-1:0] o_exp_data;

    typedef struct packed {
        logic        locked;
        logic        err;
        logic [31:0] err_cnt;
        logic [31:0] word_cnt;
        logic        done;
        logic [31:0] tag;
    } exp_t;

    exp_t exp_q[$];
    int   num_checks = 0;
    int   num_fail   = 0;

    lfsr_checker dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_clear    (i_clear),
        .i_vld      (i_vld),
        .i_data     (i_data),
        .i_stop_code(i_stop_code),
        .o_locked   (o_locked),
        .o_err      (o_err),
        .o_err_cnt  (o_err_cnt),
        .o_word_cnt (o_word_cnt),
        .o_done     (o_done),
        .o_exp_data (o_exp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stream generator: shift left, feedback = XNOR of bit 49 and bit 40 (1-based).
    function automatic logic [NB-1:0] gen(input logic [NB-1:0] x);
        logic fb;
        fb = ~(x[48] ^ x[39]);
        return {x[47:0], fb};
    endfunction

    task automatic drive(input logic vld, input logic clr, input logic [NB-1:0] d,
                         input logic e_locked, input logic e_err, input int e_errc,
                         input int e_wc, input logic e_done, input int tag);
        exp_t e;
        @(negedge clk);
        i_vld   = vld;
        i_clear = clr;
        i_data  = d;
        e.locked   = e_locked;
        e.err      = e_err;
        e.err_cnt  = e_errc;
        e.word_cnt = e_wc;
        e.done     = e_done;
        e.tag      = tag;
        exp_q.push_back(e);
    endtask

    task automatic release_bus();
        @(negedge clk);
        i_vld   = 1'b0;
        i_clear = 1'b0;
        i_data  = '0;
    endtask

    task automatic clear_all(input int tag);
        drive(1'b1, 1'b1, 49'h1, 1'b0, 1'b0, 0, 0, 1'b0, tag);
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            num_checks++;
            if ({o_locked, o_err, o_err_cnt, o_word_cnt, o_done} !==
                {e.locked, e.err, e.err_cnt, e.word_cnt, e.done}) begin
                num_fail++;
                $display("FAIL beat_%0d got lock=%0b err=%0b errc=%0d wc=%0d done=%0b want lock=%0b err=%0b errc=%0d wc=%0d done=%0b",
                         e.tag, o_locked, o_err, o_err_cnt, o_word_cnt, o_done,
                         e.locked, e.err, e.err_cnt, e.word_cnt, e.done);
            end
        end
    end

    task automatic check_idle_outputs(input string name);
        num_checks++;
        if ({o_locked, o_err, o_err_cnt, o_word_cnt, o_done, o_exp_data} !== '0) begin
            num_fail++;
            $display("FAIL %s got lock=%0b err=%0b errc=%0d wc=%0d done=%0b exp=%h want all zero",
                     name, o_locked, o_err, o_err_cnt, o_word_cnt, o_done, o_exp_data);
        end
    endtask

    initial begin
        logic [NB-1:0] g;
        logic [NB-1:0] d;
        int            wc;
        int            ec;
        int            waited;

        rst         = 1'b1;
        i_clear     = 1'b0;
        i_vld       = 1'b0;
        i_data      = '0;
        i_stop_code = '0;
        #23;
        check_idle_outputs("reset_state");
        @(negedge clk);
        rst = 1'b0;

        // Clean stream seeded with 1: lock after word 5, 95 words counted.
        clear_all(1000);
        g = 49'h1;
        for (int i = 1; i <= 100; i++) begin
            drive(1'b1, 1'b0, g, i >= 5, 1'b0, 0, (i >= 6) ? i - 5 : 0, 1'b0, 1000 + i);
            g = gen(g);
        end
        release_bus();

        // Single corrupted word 50: one error pulse, lock held, flywheel recovers.
        clear_all(2000);
        g = 49'h1;
        for (int i = 1; i <= 100; i++) begin
            d = (i == 50) ? (g ^ 49'h1) : g;
            drive(1'b1, 1'b0, d, i >= 5, i == 50, (i >= 50) ? 1 : 0,
                  (i >= 6) ? i - 5 : 0, 1'b0, 2000 + i);
            g = gen(g);
        end
        release_bus();

        // Words 40-43 forced to zero: four errors, lock lost at 43, relock at 48.
        clear_all(3000);
        g = 49'h1;
        for (int i = 1; i <= 100; i++) begin
            d  = (i >= 40 && i <= 43) ? '0 : g;
            ec = (i < 40) ? 0 : ((i <= 43) ? i - 39 : 4);
            if (i < 6)       wc = 0;
            else if (i <= 43) wc = i - 5;
            else if (i <= 48) wc = 38;
            else             wc = 38 + i - 48;
            drive(1'b1, 1'b0, d, (i >= 5 && i <= 42) || (i >= 48),
                  i >= 40 && i <= 43, ec, wc, 1'b0, 3000 + i);
            g = gen(g);
        end
        release_bus();

        // Stop code 7F reached at word 7; done is sticky until clear.
        i_stop_code = 49'h7F;
        clear_all(4000);
        g = 49'h1;
        for (int i = 1; i <= 7; i++) begin
            drive(1'b1, 1'b0, g, i >= 5, 1'b0, 0, (i >= 6) ? i - 5 : 0, i >= 7, 4000 + i);
            g = gen(g);
        end
        drive(1'b0, 1'b0, g, 1'b1, 1'b0, 0, 2, 1'b1, 4008);
        drive(1'b1, 1'b1, g, 1'b0, 1'b0, 0, 0, 1'b0, 4009);
        drive(1'b1, 1'b0, 49'h7F, 1'b0, 1'b0, 0, 0, 1'b0, 4010);
        release_bus();
        i_stop_code = '0;

        // Lockup word never seeds; a normal seed afterwards locks on schedule.
        clear_all(5000);
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 1'b0, 49'h1_FFFF_FFFF_FFFF, 1'b0, 1'b0, 0, 0, 1'b0, 5000 + i);
        end
        g = 49'h1;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 1'b0, g, i >= 5, 1'b0, 0, 0, 1'b0, 5100 + i);
            g = gen(g);
        end
        release_bus();

        // Asynchronous reset while locked must act between clock edges.
        waited = 0;
        while (exp_q.size() > 0 && waited < 100) begin
            @(posedge clk);
            waited++;
        end
        @(posedge clk);
        #3;
        num_checks++;
        if (o_locked !== 1'b1) begin
            num_fail++;
            $display("FAIL locked_before_reset got %0b want 1", o_locked);
        end
        rst = 1'b1;
        #1;
        check_idle_outputs("async_reset_mid_locked");
        @(negedge clk);
        rst = 1'b0;

        waited = 0;
        while (exp_q.size() > 0 && waited < 100) begin
            @(posedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            num_checks++;
            num_fail++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_fail);
        $finish;
    end

endmodule
